// File: rtl/fifo_async_pkg.sv
// Shared helpers for the dual-clock FIFO pointer logic: Gray/binary conversion
// and the default pointer width.
package fifo_async_pkg;

  localparam int unsigned ADDR_SIZE_DEF = 6;
  localparam int unsigned PTR_W         = ADDR_SIZE_DEF + 1;
  localparam int unsigned CONV_W        = 32;

  // Callers zero-extend to CONV_W; leading zeros leave both conversions unchanged.
  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
    logic [CONV_W-1:0] b;
    b = g;
    for (int i = 1; i < CONV_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_ctrl_if.sv
// Writer-side bus of the async FIFO write controller.
// almost_full exists only when FIFO_ALMOST_FULL_EN is defined.
interface fifo_wptr_full_ctrl_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_SIZE = 6
);
  localparam int unsigned PW = ADDR_SIZE + 1;

  logic             W_REQ;
  logic [WIDTH-1:0] data_in;
  logic [PW-1:0]    G_R_address_async;
  logic             W_EN;
  logic [WIDTH-1:0] data_w;
  logic [PW-1:0]    B_W_address;
  logic [PW-1:0]    G_W_address;
  logic             full;
  logic             overflow;
  logic [PW-1:0]    wr_count;

`ifdef FIFO_ALMOST_FULL_EN
  logic             almost_full;

  modport master (output W_REQ, data_in, G_R_address_async,
                  input  W_EN, data_w, B_W_address, G_W_address, full, overflow, wr_count,
                         almost_full);
  modport slave  (input  W_REQ, data_in, G_R_address_async,
                  output W_EN, data_w, B_W_address, G_W_address, full, overflow, wr_count,
                         almost_full);
`else
  modport master (output W_REQ, data_in, G_R_address_async,
                  input  W_EN, data_w, B_W_address, G_W_address, full, overflow, wr_count);
  modport slave  (input  W_REQ, data_in, G_R_address_async,
                  output W_EN, data_w, B_W_address, G_W_address, full, overflow, wr_count);
`endif

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for Gray-coded pointers crossing clock domains.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/fifo_wptr_full_ctrl.sv
// Async FIFO write-side control: write pointer, read-pointer sync, full/overflow/fill level.
// Optional almost_full output under FIFO_ALMOST_FULL_EN.
module fifo_wptr_full_ctrl
  import fifo_async_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_SIZE = 6,
  parameter int unsigned AF_THRESH = 60
) (
  input  logic                  CLK_w,
  input  logic                  RST_n_r,
  fifo_wptr_full_ctrl_if.slave  bus
);

  localparam int unsigned PW = ADDR_SIZE + 1;

  if (DEPTH != (1 << ADDR_SIZE)) begin : g_bad_depth
    $error("DEPTH must equal 2**ADDR_SIZE");
  end
  if (ADDR_SIZE < 2 || WIDTH == 0 || AF_THRESH > DEPTH) begin : g_bad_cfg
    $error("bad ADDR_SIZE/WIDTH/AF_THRESH");
  end

  logic [PW-1:0] b_q, b_d;
  logic [PW-1:0] g_q, g_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rq2_bin_c;
  logic [PW-1:0] full_tgt_c;
  logic          w_en_c;

  sync_2ff #(.W(PW)) u_rsync (
    .clk   (CLK_w),
    .rst_n (RST_n_r),
    .d     (bus.G_R_address_async),
    .q     (rq2)
  );

  // Full when the next write pointer equals the synced read pointer with the top two Gray bits inverted.
  always_comb begin
    w_en_c     = bus.W_REQ & ~full_q;
    rq2_bin_c  = PW'(gray2bin(CONV_W'(rq2)));
    full_tgt_c = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
    b_d        = b_q + PW'(w_en_c);
    g_d        = PW'(bin2gray(CONV_W'(b_d)));
    full_d     = (g_d == full_tgt_c);
    ovf_d      = bus.W_REQ & full_q;
  end

  always_ff @(posedge CLK_w or negedge RST_n_r) begin
    if (!RST_n_r) begin
      b_q    <= '0;
      g_q    <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      b_q    <= b_d;
      g_q    <= g_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

  logic af_q, af_d;

  // Looks one cycle ahead so the flag is registered yet aligned with wr_count.
  always_comb begin
    af_d = (PW'(b_d - rq2_bin_c) >= AF_LVL);
  end

  always_ff @(posedge CLK_w or negedge RST_n_r) begin
    if (!RST_n_r) af_q <= 1'b0;
    else          af_q <= af_d;
  end

  assign bus.almost_full = af_q;
`endif

  assign bus.W_EN        = w_en_c;
  assign bus.data_w      = bus.data_in;
  assign bus.B_W_address = b_q;
  assign bus.G_W_address = g_q;
  assign bus.full        = full_q;
  assign bus.overflow    = ovf_q;
  assign bus.wr_count    = PW'(b_q - rq2_bin_c);

endmodule

// File: tb/tb_fifo_wptr_full_ctrl.sv
// Randomised self-checking bench for fifo_wptr_full_ctrl against an occupancy-level model.
// Define FIFO_ALMOST_FULL_EN to also check almost_full.
module tb_fifo_wptr_full_ctrl;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned DEPTH     = 64;
  localparam int unsigned ADDR_SIZE = 6;
  localparam int unsigned AF_THRESH = 60;
  localparam int          PTRS      = 2 * DEPTH;

  logic CLK_w   = 1'b0;
  logic RST_n_r = 1'b0;

  fifo_wptr_full_ctrl_if #(.WIDTH(WIDTH), .ADDR_SIZE(ADDR_SIZE)) wif ();

  fifo_wptr_full_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_SIZE(ADDR_SIZE), .AF_THRESH(AF_THRESH)
  ) dut (
    .CLK_w   (CLK_w),
    .RST_n_r (RST_n_r),
    .bus     (wif)
  );

  always #5 CLK_w = ~CLK_w;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: pointers as plain counts modulo 2*DEPTH; read pointer seen after a 2-edge delay.
  int wr = 0;
  int rd = 0;
  int sync_dly[$];
  bit exp_full = 1'b0;
  bit exp_ovf  = 1'b0;
  bit exp_af   = 1'b0;

  function automatic int gray(input int x);
    return x ^ (x >> 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_all(input int push, input int prev_g);
    check_eq("b_w_address", 32'(wif.B_W_address), 32'(wr));
    check_eq("g_w_address", 32'(wif.G_W_address), 32'(gray(wr)));
    check_eq("full", 32'(wif.full), 32'(exp_full));
    check_eq("overflow", 32'(wif.overflow), 32'(exp_ovf));
    check_eq("wr_count", 32'(wif.wr_count), 32'((wr - sync_dly[0] + PTRS) % PTRS));
    check_eq("gray_step", 32'($countones(7'(wif.G_W_address) ^ 7'(prev_g))), 32'(push));
`ifdef FIFO_ALMOST_FULL_EN
    check_eq("almost_full", 32'(wif.almost_full), 32'(exp_af));
`endif
  endtask

  task automatic model_reset();
    wr = 0;
    rd = 0;
    sync_dly = '{0, 0};
    exp_full = 1'b0;
    exp_ovf  = 1'b0;
    exp_af   = 1'b0;
    wif.W_REQ = 1'b0;
    wif.G_R_address_async = '0;
  endtask

  // One write-clock cycle: drive at negedge, check W_EN, then check registered state after the edge.
  task automatic step(input bit req, input bit rd_inc);
    logic [31:0] din;
    int push, nwr, rq2b, nocc, prev_g;
    bit nfull, novf, naf;
    @(negedge CLK_w);
    if (rd_inc) rd = (rd + 1) % PTRS;
    din = $urandom;
    wif.W_REQ = req;
    wif.data_in = din;
    wif.G_R_address_async = 7'(gray(rd));
    #1;
    check_eq("w_en", 32'(wif.W_EN), 32'(req && !exp_full));
    check_eq("data_w", wif.data_w, din);
    push  = (req && !exp_full) ? 1 : 0;
    rq2b  = sync_dly[0];
    nwr   = (wr + push) % PTRS;
    nocc  = (nwr - rq2b + PTRS) % PTRS;
    nfull = (nocc == DEPTH);
    novf  = req && exp_full;
    naf   = (nocc >= AF_THRESH);
    @(posedge CLK_w);
    #1;
    prev_g   = gray(wr);
    wr       = nwr;
    exp_full = nfull;
    exp_ovf  = novf;
    exp_af   = naf;
    void'(sync_dly.pop_front());
    sync_dly.push_back(rd);
    check_all(push, prev_g);
  endtask

  function automatic int occ();
    return (wr - rd + PTRS) % PTRS;
  endfunction

  initial begin
    int guard;
    wif.data_in = '0;
    model_reset();
    #1;
    check_eq("rst_b", 32'(wif.B_W_address), 32'd0);
    check_eq("rst_full", 32'(wif.full), 32'd0);
    @(negedge CLK_w);
    RST_n_r = 1'b1;

    // Async reset in the middle of a burst, checked before any further edge.
    for (int i = 0; i < 21; i++) step(1'b1, 1'b0);
    check_eq("pre_rst_b", 32'(wif.B_W_address), 32'h15);
    wif.W_REQ = 1'b1;
    @(posedge CLK_w);
    #2;
    RST_n_r = 1'b0;
    #1;
    check_eq("midrst_b", 32'(wif.B_W_address), 32'd0);
    check_eq("midrst_g", 32'(wif.G_W_address), 32'd0);
    check_eq("midrst_full", 32'(wif.full), 32'd0);
    check_eq("midrst_cnt", 32'(wif.wr_count), 32'd0);
    model_reset();
    @(negedge CLK_w);
    RST_n_r = 1'b1;

    // Fill to full with the read pointer held at zero.
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0);
    check_eq("fill_full", 32'(wif.full), 32'd1);
    check_eq("fill_b", 32'(wif.B_W_address), 32'h40);
    check_eq("fill_g", 32'(wif.G_W_address), 32'h60);
    check_eq("fill_cnt", 32'(wif.wr_count), 32'd64);

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      check_eq("ovf_pulse", 32'(wif.overflow), 32'd1);
      check_eq("ovf_b_hold", 32'(wif.B_W_address), 32'h40);
    end
    step(1'b0, 1'b0);
    check_eq("ovf_clear", 32'(wif.overflow), 32'd0);

    // One read frees a slot after the synchroniser latency.
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("drain_full", 32'(wif.full), 32'd0);
    check_eq("drain_cnt", 32'(wif.wr_count), 32'd63);
    step(1'b1, 1'b0);
    check_eq("refull", 32'(wif.full), 32'd1);

    // Walk the pointer up to 7'h7F, then wrap.
    guard = 0;
    while (wr != PTRS - 1 && guard < 1000) begin
      step(1'b1, occ() > 32);
      guard++;
    end
    check_eq("wrap_pre_b", 32'(wif.B_W_address), 32'h7F);
    check_eq("wrap_pre_g", 32'(wif.G_W_address), 32'h40);
    step(1'b1, 1'b1);
    check_eq("wrap_b", 32'(wif.B_W_address), 32'h00);
    check_eq("wrap_g", 32'(wif.G_W_address), 32'h00);

`ifdef FIFO_ALMOST_FULL_EN
    RST_n_r = 1'b0;
    #1;
    model_reset();
    @(negedge CLK_w);
    RST_n_r = 1'b1;
    for (int i = 0; i < 59; i++) step(1'b1, 1'b0);
    check_eq("af_59", 32'(wif.almost_full), 32'd0);
    step(1'b1, 1'b0);
    check_eq("af_60", 32'(wif.almost_full), 32'd1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("af_drop", 32'(wif.almost_full), 32'd0);
`endif

    // Random traffic in write-heavy and read-heavy phases.
    for (int ph = 0; ph < 4; ph++) begin
      int wp;
      int rp;
      wp = (ph % 2 == 0) ? 85 : 30;
      rp = (ph % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 600; i++) begin
        bit req;
        bit rdi;
        req = ($urandom_range(0, 99) < wp);
        rdi = (occ() > 0) && ($urandom_range(0, 99) < rp);
        step(req, rdi);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
